// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encodings and bus constants for the target and the master.
//   tgt_state_e : register-port target FSM states
//   mst_state_e : ADC-config master FSM states
//   ACK/NACK    : SDA level in the acknowledge slot
//   RW_BIT      : position of the R/W flag in the address byte
//   ACK_SLOT    : bit counter value while the 9th (acknowledge) clock is pending
package i2c_pkg;
  typedef enum logic [2:0] {
    T_IDLE, T_ADDR, T_ADDR_ACK, T_PTR, T_WR_BYTE, T_RD_BYTE, T_IGNORE
  } tgt_state_e;
  typedef enum logic [2:0] {
    M_IDLE, M_START, M_ADDR, M_DATA, M_ACK, M_STOP
  } mst_state_e;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam int RW_BIT = 0;
  localparam logic [3:0] ACK_SLOT = 4'd8;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronizer, glitch filter and edge/START/STOP detector for one SCL/SDA pair.
//   clk, reset          : system clock, sync active-high reset (filter state resets to bus idle)
//   scl_i, sda_i        : raw pin levels
//   sda                 : filtered SDA level
//   scl_rise, scl_fall  : one-cycle filtered SCL edges
//   start_det, stop_det : one-cycle START / STOP conditions
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [1:0] s1_q, s2_q, flt_q, flt_d;
  logic [1:0][FILT_LEN-2:0] hist_q, hist_d;
  logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d;
  // Index 0 is SCL, index 1 is SDA; a level is accepted once the current
  // synchronized sample and the FILT_LEN-1 before it all agree.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hist_d[i] = (hist_q[i] << 1) | (FILT_LEN-1)'(s2_q[i]);
      flt_d[i] = (hist_q[i] == {(FILT_LEN-1){s2_q[i]}}) ? s2_q[i] : flt_q[i];
    end
    rise_d = flt_d[0] & ~flt_q[0];
    fall_d = ~flt_d[0] & flt_q[0];
    start_d = flt_q[0] & flt_d[0] & flt_q[1] & ~flt_d[1];
    stop_d = flt_q[0] & flt_d[0] & ~flt_q[1] & flt_d[1];
  end
  always_ff @(posedge clk)
    if (reset) begin
      s1_q <= '1;
      s2_q <= '1;
      hist_q <= '1;
      flt_q <= '1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      s1_q <= {sda_i, scl_i};
      s2_q <= s1_q;
      hist_q <= hist_d;
      flt_q <= flt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      start_q <= start_d;
      stop_q <= stop_d;
    end
  assign sda = flt_q[1];
  assign scl_rise = rise_q;
  assign scl_fall = fall_q;
  assign start_det = start_q;
  assign stop_det = stop_q;
endmodule

// File: rtl/i2c_target_regfile_port.sv
// i2c_target_regfile_port: I2C target giving a host MCU read/write access to 8-bit control registers.
//   clk, reset            : 50 MHz system clock, sync active-high reset
//   scl_i, sda_i          : raw bus pins; sda_oe pulls SDA low (open drain)
//   reg_addr/reg_wdata    : register pointer and write data presented with the strobes
//   reg_wr_en/reg_rd_en   : one-cycle write strobe / read request
//   reg_rdata             : read data, valid one clk after reg_rd_en
//   busy                  : high from address match until STOP, repeated START or NACKed read
module i2c_target_regfile_port import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  logic sda, scl_rise, scl_fall, start_det, stop_det;
  tgt_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d, reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, reg_wr_en_q, reg_wr_en_d, reg_rd_en_q, reg_rd_en_d;
  logic rd_pend_q, rd_pend_d;
  logic [7:0] shift_in;
  logic data_rise, last_rise, ack_rise, ack_fall, end_fall;
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
  );
  // bit_cnt: 0..7 data bits, ACK_SLOT after the 8th rise, ACK_SLOT+1 after the 9th rise
  assign shift_in = {shift_q[6:0], sda};
  assign data_rise = scl_rise && bit_cnt_q < ACK_SLOT;
  assign last_rise = scl_rise && bit_cnt_q == ACK_SLOT - 4'd1;
  assign ack_fall = scl_fall && bit_cnt_q == ACK_SLOT;
  assign ack_rise = scl_rise && bit_cnt_q == ACK_SLOT;
  assign end_fall = scl_fall && bit_cnt_q == ACK_SLOT + 4'd1;
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    ptr_d = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d = busy_q;
    reg_addr_d = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_en_d = 1'b0;
    reg_rd_en_d = 1'b0;
    rd_pend_d = reg_rd_en_q;
    if (data_rise) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      shift_d = state_q == T_RD_BYTE ? {shift_q[6:0], 1'b0} : shift_in;
    end
    if (ack_rise) bit_cnt_d = ACK_SLOT + 4'd1;
    if (end_fall) bit_cnt_d = 4'd0;
    if (rd_pend_q) shift_d = reg_rdata;
    case (state_q)
      T_ADDR: if (last_rise) begin
        state_d = shift_in[7:1] == DEV_ADDR ? T_ADDR_ACK : T_IGNORE;
        busy_d = shift_in[7:1] == DEV_ADDR;
      end
      T_ADDR_ACK: begin
        if (ack_fall) sda_oe_d = ~ACK;
        // Reads leave at the ACK rise so the prefetch happens before the R/W bit is overwritten.
        if (ack_rise && shift_q[RW_BIT]) begin
          state_d = T_RD_BYTE;
          reg_rd_en_d = 1'b1;
          reg_addr_d = ptr_q;
        end
        if (end_fall) begin
          state_d = T_PTR;
          sda_oe_d = 1'b0;
        end
      end
      T_PTR: begin
        if (last_rise) ptr_d = shift_in;
        if (ack_fall) sda_oe_d = ~ACK;
        if (end_fall) begin
          state_d = T_WR_BYTE;
          sda_oe_d = 1'b0;
        end
      end
      T_WR_BYTE: begin
        if (last_rise) begin
          reg_wr_en_d = 1'b1;
          reg_addr_d = ptr_q;
          reg_wdata_d = shift_in;
          ptr_d = ptr_q + 8'd1;
        end
        if (ack_fall) sda_oe_d = ~ACK;
        if (end_fall) sda_oe_d = 1'b0;
      end
      T_RD_BYTE: begin
        // Every fall drives the next MSB, except the one before the host's ACK slot.
        if (scl_fall) sda_oe_d = bit_cnt_q != ACK_SLOT && !shift_q[7];
        if (ack_rise) begin
          if (sda == NACK) begin
            state_d = T_IGNORE;
            busy_d = 1'b0;
          end else begin
            ptr_d = ptr_q + 8'd1;
            reg_rd_en_d = 1'b1;
            reg_addr_d = ptr_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    if (start_det) begin
      state_d = T_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
    end
    if (stop_det) begin
      state_d = T_IDLE;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= T_IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      ptr_q <= '0;
      sda_oe_q <= 1'b0;
      busy_q <= 1'b0;
      reg_addr_q <= '0;
      reg_wdata_q <= '0;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      ptr_q <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q <= busy_d;
      reg_addr_q <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_rd_en_q <= reg_rd_en_d;
      rd_pend_q <= rd_pend_d;
    end
  assign sda_oe = sda_oe_q;
  assign busy = busy_q;
  assign reg_addr = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_rd_en = reg_rd_en_q;
endmodule

// File: tb/tb_i2c_target_regfile_port.sv
// tb_i2c_target_regfile_port: directed host-side stimulus for the I2C register-port target.
module tb_i2c_target_regfile_port;
  localparam int Q = 32;
  logic clk = 1'b0, reset = 1'b1, scl_h = 1'b1, sda_h = 1'b1;
  logic sda_line, sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  int checks = 0, errors = 0, acks = 0, rd_cnt = 0;
  bit oe_seen = 0, busy_seen = 0;
  logic [15:0] wr_log [$];
  assign sda_line = sda_h & ~sda_oe;
  always #10 clk = ~clk;
  i2c_target_regfile_port dut (
    .clk(clk), .reset(reset), .scl_i(scl_h), .sda_i(sda_line), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata), .busy(busy)
  );
  // register bank model: data = addr ^ 0x5A, valid only the cycle after the request
  always @(posedge clk) reg_rdata <= reg_rd_en ? (reg_addr ^ 8'h5A) : 8'h00;
  always @(negedge clk) begin
    if (reg_wr_en) wr_log.push_back({reg_addr, reg_wdata});
    if (reg_rd_en) rd_cnt++;
    if (sda_oe) oe_seen = 1;
    if (busy) busy_seen = 1;
    if (reg_wr_en || reg_rd_en) begin
      checks++;
      if (reg_wr_en && reg_rd_en) begin
        errors++;
        $display("FAIL strobe_overlap wr=%b rd=%b required not both", reg_wr_en, reg_rd_en);
      end
    end
  end
  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask
  task automatic bus_start();
    sda_h = 1; wq(); scl_h = 1; wq(); sda_h = 0; wq(); scl_h = 0; wq();
  endtask
  task automatic bus_stop();
    sda_h = 0; wq(); scl_h = 1; wq(); sda_h = 1; wq(); wq();
  endtask
  task automatic send_bit(input logic b, input bit glitch = 0);
    sda_h = b; wq(); scl_h = 1; wq();
    if (glitch) begin
      scl_h = 0;
      repeat (2) @(negedge clk);
      scl_h = 1;
    end
    wq(); scl_h = 0; wq();
  endtask
  task automatic read_bit(output logic b);
    sda_h = 1; wq(); scl_h = 1; wq(); b = sda_line; wq(); scl_h = 0; wq();
  endtask
  task automatic write_byte(input logic [7:0] d, input int glitch_bit = -1);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
    read_bit(b);
    if (b == 1'b0) acks++;
  endtask
  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    send_bit(~ack);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if ({sda_oe, busy, reg_wr_en, reg_rd_en, reg_addr, reg_wdata} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got oe=%b busy=%b wr=%b rd=%b addr=%h wdata=%h required all 0",
               sda_oe, busy, reg_wr_en, reg_rd_en, reg_addr, reg_wdata);
    end
  endtask
  task automatic test_write();
    acks = 0; wr_log.delete();
    bus_start(); write_byte(8'h90); write_byte(8'h1A); write_byte(8'h11);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b required 1", busy); end
    write_byte(8'h22); bus_stop();
    checks++;
    if (acks != 4) begin errors++; $display("FAIL write_acks got %0d required 4", acks); end
    checks++;
    if (wr_log.size() != 2 || wr_log[0] !== 16'h1A11 || wr_log[1] !== 16'h1B22) begin
      errors++;
      $display("FAIL write_strobes got n=%0d %h %h required 2 1a11 1b22", wr_log.size(), wr_log[0], wr_log[1]);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got %b required 0", busy); end
  endtask
  task automatic test_wrong_addr();
    acks = 0; rd_cnt = 0; oe_seen = 0; busy_seen = 0; wr_log.delete();
    bus_start(); write_byte(8'h92); write_byte(8'h55); bus_stop();
    checks++;
    if (acks != 0) begin errors++; $display("FAIL wrong_acks got %0d required 0", acks); end
    checks++;
    if (oe_seen) begin errors++; $display("FAIL wrong_sda_oe got 1 required 0"); end
    checks++;
    if (busy_seen) begin errors++; $display("FAIL wrong_busy got 1 required 0"); end
    checks++;
    if (wr_log.size() != 0 || rd_cnt != 0) begin
      errors++;
      $display("FAIL wrong_strobes got wr=%0d rd=%0d required 0 0", wr_log.size(), rd_cnt);
    end
  endtask
  task automatic test_combined_read();
    logic [7:0] d0, d1, d2;
    acks = 0; rd_cnt = 0; wr_log.delete();
    bus_start(); write_byte(8'h90); write_byte(8'hFE);
    bus_start(); write_byte(8'h91);
    read_byte(d0, 1); read_byte(d1, 1); read_byte(d2, 0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_nack got %b required 0", busy); end
    bus_stop();
    checks++;
    if (acks != 3) begin errors++; $display("FAIL read_acks got %0d required 3", acks); end
    checks++;
    if ({d0, d1, d2} !== 24'hA4A55A) begin
      errors++;
      $display("FAIL read_data got %h %h %h required a4 a5 5a", d0, d1, d2);
    end
    checks++;
    if (rd_cnt != 3) begin errors++; $display("FAIL read_rd_en got %0d required 3", rd_cnt); end
    checks++;
    if (wr_log.size() != 0) begin errors++; $display("FAIL read_wr_en got %0d required 0", wr_log.size()); end
  endtask
  task automatic test_abort();
    acks = 0; wr_log.delete();
    bus_start(); write_byte(8'h90); write_byte(8'h30);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus_start(); write_byte(8'h90);
    checks++;
    if (acks != 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_readdr got acks=%0d busy=%b required 3 1", acks, busy);
    end
    bus_stop();
    checks++;
    if (wr_log.size() != 0) begin errors++; $display("FAIL abort_wr_en got %0d required 0", wr_log.size()); end
  endtask
  task automatic test_glitch();
    acks = 0; wr_log.delete();
    bus_start(); write_byte(8'h90); write_byte(8'h40); write_byte(8'h3C, 3); bus_stop();
    checks++;
    if (acks != 3) begin errors++; $display("FAIL glitch_acks got %0d required 3", acks); end
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== 16'h403C) begin
      errors++;
      $display("FAIL glitch_strobe got n=%0d %h required 1 403c", wr_log.size(), wr_log[0]);
    end
  endtask
  task automatic test_reset_mid_read();
    logic [7:0] d;
    bus_start(); write_byte(8'h91);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL midrd_pre_oe got %b required 1", sda_oe); end
    reset = 1; scl_h = 1; sda_h = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if ({sda_oe, busy, reg_wr_en, reg_rd_en, reg_addr, reg_wdata} !== 20'h0) begin
      errors++;
      $display("FAIL midrd_reset got oe=%b busy=%b wr=%b rd=%b addr=%h wdata=%h required all 0",
               sda_oe, busy, reg_wr_en, reg_rd_en, reg_addr, reg_wdata);
    end
    wq();
    acks = 0;
    bus_start(); write_byte(8'h91); read_byte(d, 0); bus_stop();
    checks++;
    if (acks != 1 || d !== 8'h5A) begin
      errors++;
      $display("FAIL midrd_after got acks=%0d data=%h required 1 5a", acks, d);
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_combined_read();
    test_abort();
    test_glitch();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
